// File: rtl/if_fetch_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_pkg
// Shared widths, constants and the FIFO entry type for the instruction
// prefetch stage (if_prefetch_buffer and its fetch_fifo).
// ----------------------------------------------------------------------------
package if_fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  // The prefetcher only ever reads, so every byte write enable stays high.
  localparam logic [3:0]        IM_WEB_READ = 4'hF;
  localparam logic [ADDR_W-1:0] PC_STEP     = 32'd4;

  // One captured instruction together with the address it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   flush         drop all entries; wins over push and pop
//   push, din     write din at the tail
//   pop           advance the head; ignored while empty
//   dout          entry at the head (meaningful only while count != 0)
//   count         occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: storage has no reset; the occupancy count alone decides validity,
  // which keeps the array a plain register file / RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// if_prefetch_buffer
// Instruction prefetch stage between fetch/decode and the instruction SRAM.
// Issues one sequential word read per cycle while FIFO credit remains,
// captures the returning words, and hands them to decode with valid/ready.
// A redirect flushes everything in flight and restarts at the new PC.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   redirect_valid, redirect_pc  branch/jump/trap redirect (pc[1:0] ignored)
//   inst_valid, inst, inst_pc    FIFO head to decode
//   inst_ready                   decode consumes the head
//   IM_CS, IM_OE, IM_WEB         SRAM controls (WEB held at read)
//   IM_addr, IM_data_out         SRAM byte address / read data (1-cycle latency)
// ----------------------------------------------------------------------------
module if_prefetch_buffer
  import if_fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              IM_CS,
  output logic              IM_OE,
  output logic [3:0]        IM_WEB,
  output logic [ADDR_W-1:0] IM_addr,
  input  logic [INST_W-1:0] IM_data_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic              rsp_pending;
  logic [CW-1:0]     count;
  logic [CW:0]       committed;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic [1:0]        unused_pc_bits;

  assign unused_pc_bits = redirect_pc[1:0];

  // Credit counts words already buffered plus the one still in the SRAM.
  // A pop this cycle is deliberately not credited (no lookahead).
  assign committed = {1'b0, count} + (CW + 1)'(rsp_pending);

  // Gated by rst so the SRAM sees no request while held in reset.
  assign issue = rst & ~redirect_valid & (committed < (CW + 1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rsp_pending <= 1'b0;
    end else if (redirect_valid) begin
      // Any read already in flight is dropped by clearing rsp_pending.
      fetch_pc    <= word_align(redirect_pc);
      rsp_pending <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + PC_STEP;
      rsp_pc      <= fetch_pc;
      rsp_pending <= 1'b1;
    end else begin
      rsp_pending <= 1'b0;
    end
  end

  assign push       = rsp_pending & ~redirect_valid;
  assign push_entry = '{pc: rsp_pc, inst: IM_data_out};
  assign pop        = inst_valid & inst_ready;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  assign IM_CS   = issue;
  assign IM_OE   = issue | rsp_pending;
  assign IM_WEB  = IM_WEB_READ;
  assign IM_addr = fetch_pc;

endmodule

// File: doc/if_prefetch_buffer.md
Name: if_prefetch_buffer

Overview:
Instruction prefetch stage between the CPU fetch/decode front end and the instruction-memory SRAM_wrapper. It owns the IM port (CS/OE/WEB/addr), issues one sequential read per cycle while buffer credit remains, and captures returning words into a small FIFO. It presents instructions to decode with a valid/ready handshake and flushes on branch/jump redirect.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >= 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
redirect_valid  input  1  CPU redirect request (branch/jump/trap taken)
redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0)
inst_valid  output  1  FIFO head valid
inst  output  32  instruction at FIFO head
inst_pc  output  32  PC of instruction at FIFO head
inst_ready  input  1  decode accepts head this cycle
IM_CS  output  1  SRAM chip select (read request)
IM_OE  output  1  SRAM output enable
IM_WEB  output  4  SRAM byte write enables, active-low; constant 4'hF
IM_addr  output  32  SRAM byte address; the top level uses [15:2]
IM_data_out  input  32  SRAM read data

Behaviour:
- SRAM timing: address sampled at the clk edge ending a cycle with IM_CS=1; IM_data_out is valid throughout the next cycle.
- State: fetch_pc, rsp_pending (1 bit), rsp_pc, FIFO storage, occupancy count (0..DEPTH).
- Reset (rst=0, async): fetch_pc=RESET_PC, rsp_pending=0, occupancy=0. Outputs: inst_valid=0, IM_CS=0, IM_OE=0, IM_WEB=4'hF, IM_addr=RESET_PC; inst/inst_pc don't-care.
- Issue: IM_CS=1 and IM_addr=fetch_pc when (occupancy + rsp_pending) < DEPTH and redirect_valid=0. This is combinational from registered state. On issue: fetch_pc += 4 (wraps mod 2^32), rsp_pending<=1, rsp_pc<=fetch_pc. Otherwise rsp_pending<=0.
- No pop lookahead in the issue credit check; a full FIFO stalls issue for one extra cycle after a pop.
- IM_OE = IM_CS | rsp_pending.
- Capture: in a cycle with rsp_pending=1 and redirect_valid=0, {rsp_pc, IM_data_out} is pushed at the end of the cycle. The credit rule guarantees the push never overflows.
- Pop: inst_valid & inst_ready advances the head. Push and pop may occur in the same cycle, and occupancy is then unchanged.
- No bypass: an issued word reaches inst_valid two cycles after its request cycle. First inst_valid appears in cycle 2 after reset release, where cycle 0 is the first cycle with rst=1.
- Redirect (priority over issue, push and pop):
  - occupancy<=0 and head/tail are reset.
  - Any pending response is discarded: rsp_pending<=0, and no push occurs that cycle.
  - fetch_pc<={redirect_pc[31:2],2'b00}.
  - IM_CS=0 that cycle. The first request at the new PC is issued the next cycle.
  - inst_valid may be 1 during the redirect cycle. A pop in that cycle is ignored by the FIFO, and decode must squash it.
- Back-to-back redirects: each redirect overrides the previous one. Only the last redirect_pc is fetched.
- Reset asserted mid-operation clears all state immediately. Any in-flight SRAM read is dropped.
- inst_ready=1 with inst_valid=0 has no effect.

Decomposition:
- Package if_fetch_pkg:
  - INST_W=32
  - ADDR_W=32
  - IM_WEB_READ=4'hF
  - PC_STEP=32'd4
  - fetch_entry_t struct {pc[31:0], inst[31:0]}
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t, depth DEPTH.
  - Ports: push, pop, flush, count.
  - Async active-low reset.
  - flush has priority over push and pop.
- The top module holds the PC/issue/credit logic.

Test Plan:
- Reset release, inst_ready=1, SRAM word[i]=32'h1000_0000+i -> IM_addr 0,4,8,... one per cycle. inst_valid rises in cycle 2 with inst=32'h1000_0000, inst_pc=0, then one instruction per cycle in order.
- inst_ready=0 from reset -> exactly 4 requests (addresses 0x0,0x4,0x8,0xC). IM_CS=0 from cycle 4, occupancy=4, head inst_pc=0. Raise ready -> next request at 0x10 after the first pop.
- Redirect to 32'h0000_0103 in the cycle after request at 0x8 is issued -> word for 0x8 is not captured and inst_valid drops next cycle. Next request is IM_addr=0x100, and the first post-redirect inst_pc=0x100.
- Redirect pulsed in consecutive cycles with pc 0x200 then 0x300 -> no fetch at 0x200, and the first request after the pulses is 0x300.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> IM_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, with inst_pc matching.
- Assert rst low while rsp_pending=1 and occupancy=3 -> inst_valid=0 and IM_CS=0 immediately (asynchronous). After release, fetch restarts at RESET_PC with no stale entries delivered. IM_WEB=4'hF throughout.
